// File: rtl/ula_pkg.sv
// Shared constants for the 74181-style ALU: default width, mode values and
// select encodings of the commonly used functions.
package ula_pkg;

  localparam int ULA_WIDTH = 8;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Arithmetic-mode selects (m = MODE_ARITH)
  localparam logic [3:0] OP_A      = 4'b0000;
  localparam logic [3:0] OP_MINUS1 = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_ADD    = 4'b1001;
  localparam logic [3:0] OP_DOUBLE = 4'b1100;
  localparam logic [3:0] OP_DEC    = 4'b1111;

  // Logic-mode selects (m = MODE_LOGIC)
  localparam logic [3:0] OP_NOT_A  = 4'b0000;
  localparam logic [3:0] OP_ZERO   = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b1011;
  localparam logic [3:0] OP_ONES   = 4'b1100;
  localparam logic [3:0] OP_PASS_A = 4'b1111;

endpackage

// File: rtl/ula_4bit_slice.sv
// Combinational 4-bit 74181 slice, active-high data. Carry out is forced low
// in logic mode so the ripple chain carries nothing between slices there.
module ula_4bit_slice
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  always_comb begin
    x    = a | ({4{s[0]}} & b) | ({4{s[1]}} & ~b);
    y    = ({4{s[2]}} & a & ~b) | ({4{s[3]}} & a & b);
    sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    f    = sum[3:0];
    cout = sum[4];
    if (m == MODE_LOGIC) begin
      f    = ~(x ^ y);
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/ula_8bit.sv
// Registered ALU built from a ripple chain of 4-bit 74181 slices; f, c_out
// and the all-ones flag are captured every clock.
module ula_8bit
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b
);

  localparam int NSL = WIDTH / 4;

  logic [NSL:0]       carry;
  logic [WIDTH-1:0]   f_sl;
  logic [WIDTH-1:0]   f_d;
  logic [WIDTH-1:0]   f_q;
  logic               c_out_d;
  logic               c_out_q;
  logic               a_eq_b_d;
  logic               a_eq_b_q;

  assign carry[0] = c_in;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    ula_4bit_slice u_slice (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .s    (s),
      .m    (m),
      .cin  (carry[i]),
      .f    (f_sl[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  // a_eq_b mirrors the 74181 A=B pin: it is simply "result is all ones"
  always_comb begin
    f_d      = f_sl;
    c_out_d  = carry[NSL];
    a_eq_b_d = &f_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q      <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
    end else begin
      f_q      <= f_d;
      c_out_q  <= c_out_d;
      a_eq_b_q <= a_eq_b_d;
    end
  end

  assign f      = f_q;
  assign c_out  = c_out_q;
  assign a_eq_b = a_eq_b_q;

endmodule

// File: tb/tb_ula_8bit.sv
// Bench for ula_8bit: reset behaviour, directed function checks, and a random
// sweep of every s/m/c_in combination against a function-table model.
module tb_ula_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] s;
  logic       m;
  logic       c_in;
  logic [7:0] f;
  logic       c_out;
  logic       a_eq_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ula_8bit #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .s      (s),
    .m      (m),
    .c_in   (c_in),
    .f      (f),
    .c_out  (c_out),
    .a_eq_b (a_eq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {a_eq_b, c_out, f} straight from the published function tables.
  // "-1" is an addition of 0xFF; A-B-1 is A plus the complement of B.
  function automatic logic [9:0] ref_alu(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic [3:0] rs, input logic rm, input logic rc);
    logic [7:0] lf;
    logic [8:0] p;
    logic [8:0] q;
    logic [8:0] r;
    logic [7:0] nb;
    nb = ~rb;
    if (rm) begin
      case (rs)
        4'd0:    lf = ~ra;
        4'd1:    lf = ~(ra | rb);
        4'd2:    lf = ~ra & rb;
        4'd3:    lf = 8'h00;
        4'd4:    lf = ~(ra & rb);
        4'd5:    lf = ~rb;
        4'd6:    lf = ra ^ rb;
        4'd7:    lf = ra & nb;
        4'd8:    lf = ~ra | rb;
        4'd9:    lf = ~(ra ^ rb);
        4'd10:   lf = rb;
        4'd11:   lf = ra & rb;
        4'd12:   lf = 8'hFF;
        4'd13:   lf = ra | nb;
        4'd14:   lf = ra | rb;
        default: lf = ra;
      endcase
      r = {1'b0, lf};
    end else begin
      case (rs)
        4'd0:    begin p = ra;        q = 0;         end
        4'd1:    begin p = ra | rb;   q = 0;         end
        4'd2:    begin p = ra | nb;   q = 0;         end
        4'd3:    begin p = 9'h0FF;    q = 0;         end
        4'd4:    begin p = ra;        q = ra & nb;   end
        4'd5:    begin p = ra | rb;   q = ra & nb;   end
        4'd6:    begin p = ra;        q = nb;        end
        4'd7:    begin p = ra & nb;   q = 9'h0FF;    end
        4'd8:    begin p = ra;        q = ra & rb;   end
        4'd9:    begin p = ra;        q = rb;        end
        4'd10:   begin p = ra | nb;   q = ra & rb;   end
        4'd11:   begin p = ra & rb;   q = 9'h0FF;    end
        4'd12:   begin p = ra;        q = ra;        end
        4'd13:   begin p = ra | rb;   q = ra;        end
        4'd14:   begin p = ra | nb;   q = ra;        end
        default: begin p = ra;        q = 9'h0FF;    end
      endcase
      r = p + q + {8'h00, rc};
    end
    return {(r[7:0] == 8'hFF), r[8], r[7:0]};
  endfunction

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                       input logic tm, input logic tc);
    @(negedge clk);
    a = ta; b = tb; s = ts; m = tm; c_in = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [3:0] ts, input logic tm, input logic tc,
                     input logic [7:0] ef, input logic ec, input logic ee);
    drive(ta, tb, ts, tm, tc);
    chk({tag, "_f"}, f, ef);
    chk({tag, "_cout"}, c_out, ec);
    chk({tag, "_aeqb"}, a_eq_b, ee);
  endtask

  initial begin
    logic [9:0] exp;
    rst_n = 1'b0;
    a = 8'h18; b = 8'h4A; s = 4'b1001; m = 1'b0; c_in = 1'b0;
    #1;
    chk("rst0_f", f, 8'h00);
    chk("rst0_cout", c_out, 1'b0);
    chk("rst0_aeqb", a_eq_b, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_add_f", f, 8'h62);

    // Reset mid-cycle must clear outputs without any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_f", f, 8'h00);
    chk("async_rst_cout", c_out, 1'b0);
    chk("async_rst_aeqb", a_eq_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_add_f", f, 8'h62);

    dir("add",      8'h18, 8'h4A, 4'b1001, 1'b0, 1'b0, 8'h62, 1'b0, 1'b0);
    dir("pass_a",   8'h18, 8'h4A, 4'b0000, 1'b0, 1'b1, 8'h19, 1'b0, 1'b0);
    dir("sub_c1",   8'h38, 8'h03, 4'b0110, 1'b0, 1'b1, 8'h35, 1'b1, 1'b0);
    dir("sub_c0",   8'h38, 8'h03, 4'b0110, 1'b0, 1'b0, 8'h34, 1'b1, 1'b0);
    dir("sub_eq",   8'h38, 8'h38, 4'b0110, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    dir("m1_c0",    8'h38, 8'h03, 4'b0011, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    dir("m1_c1",    8'h38, 8'h03, 4'b0011, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    dir("dec",      8'h38, 8'h03, 4'b1111, 1'b0, 1'b0, 8'h37, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      dir("l_xor",  8'h18, 8'h4A, 4'b0110, 1'b1, c[0], 8'h52, 1'b0, 1'b0);
      dir("l_and",  8'h18, 8'h4A, 4'b1011, 1'b1, c[0], 8'h08, 1'b0, 1'b0);
      dir("l_nota", 8'h18, 8'h4A, 4'b0000, 1'b1, c[0], 8'hE7, 1'b0, 1'b0);
      dir("l_ones", 8'h18, 8'h4A, 4'b1100, 1'b1, c[0], 8'hFF, 1'b0, 1'b1);
      dir("l_zero", 8'h18, 8'h4A, 4'b0011, 1'b1, c[0], 8'h00, 1'b0, 1'b0);
    end

    // Back-to-back random sweep over every function
    for (int k = 0; k < 32; k++) begin
      for (int r = 0; r < 8; r++) begin
        logic [7:0] ra;
        logic [7:0] rb;
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if (r == 0) rb = ra;
        drive(ra, rb, k[3:0], k[4], k[5 - 5 + 0] ^ 1'b0 ? 1'b1 : 1'b0);
        exp = ref_alu(ra, rb, k[3:0], k[4], c_in);
        chk($sformatf("rnd_s%0h_m%0d_f", k[3:0], k[4]), f, exp[7:0]);
        chk($sformatf("rnd_s%0h_m%0d_cout", k[3:0], k[4]), c_out, exp[8]);
        chk($sformatf("rnd_s%0h_m%0d_aeqb", k[3:0], k[4]), a_eq_b, exp[9]);
        // Same operands with the other carry-in on the very next cycle
        drive(ra, rb, k[3:0], k[4], ~c_in);
        exp = ref_alu(ra, rb, k[3:0], k[4], c_in);
        chk($sformatf("rnd2_s%0h_m%0d_f", k[3:0], k[4]), f, exp[7:0]);
        chk($sformatf("rnd2_s%0h_m%0d_cout", k[3:0], k[4]), c_out, exp[8]);
        chk($sformatf("rnd2_s%0h_m%0d_aeqb", k[3:0], k[4]), a_eq_b, exp[9]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
